// File: rtl/button_debounce_bank.sv
// -----------------------------------------------------------------------------
// button_debounce_bank
//   N-channel conditioner for raw board buttons and switches. Each channel has
//   a 2-FF synchronizer, a stability counter, a debounced level and registered
//   one-cycle rise/fall pulses. All outputs are synchronous to clk.
//
//   A new level is accepted only after the synchronized input has disagreed
//   with the current debounced level for STABLE_COUNT consecutive cycles. Any
//   cycle of agreement discards the partial qualification.
//
// Parameters
//   N             number of channels
//   CNT_W         stability counter width (2**CNT_W must exceed STABLE_COUNT)
//   STABLE_COUNT  consecutive mismatch cycles needed to accept a level (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   reset_n     synchronous reset, active-low
//   raw_in      asynchronous raw levels [N]
//   db_level    debounced level [N]
//   rise_pulse  one-cycle pulse, set on the edge db_level goes 0->1 [N]
//   fall_pulse  one-cycle pulse, set on the edge db_level goes 1->0 [N]
//   toggle_out  flips on every accepted rise (press-on/press-off) [N]
//
// Configuration
//   DEBOUNCE_TOGGLE_EN  defined: toggle_out is a per-channel toggle latch.
//                       undefined: toggle_out is constant zero, no flops.
// -----------------------------------------------------------------------------
module button_debounce_bank #(
  parameter int N            = 5,
  parameter int CNT_W        = 20,
  parameter int STABLE_COUNT = 1000000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] db_level,
  output logic [N-1:0] rise_pulse,
  output logic [N-1:0] fall_pulse,
  output logic [N-1:0] toggle_out
);

  // Bad parameter combinations would silently wrap the counter; stop early.
  if (STABLE_COUNT < 1 || longint'(STABLE_COUNT) >= (longint'(1) << CNT_W)) begin : g_bad_params
    $error("button_debounce_bank: need 1 <= STABLE_COUNT < 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_COUNT - 1);

  // Per-channel view: STABLE when the synchronized input agrees with the
  // debounced level, QUALIFY while it disagrees and the counter is running.
  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } chan_state_e;

  logic [N-1:0]     sync0;
  logic [N-1:0]     sync1;
  logic [CNT_W-1:0] cnt      [N];
  logic [CNT_W-1:0] cnt_next [N];
  chan_state_e      state    [N];
  logic [N-1:0]     accept;    // level accepted on this edge
  logic [N-1:0]     rise_det;  // accepted level is 1
  logic [N-1:0]     fall_det;  // accepted level is 0

  // ---------------------------------------------------------------------------
  // Next-state logic for the per-channel qualification
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    accept = '0;
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = cnt[i];
      state[i]    = (sync1[i] == db_level[i]) ? STABLE : QUALIFY;
      unique case (state[i])
        STABLE: cnt_next[i] = '0;
        QUALIFY: begin
          if (cnt[i] == LAST) begin
            accept[i]   = 1'b1;
            cnt_next[i] = '0;
          end else begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: cnt_next[i] = '0;
      endcase
    end
  end

  // An accepted change always moves db_level to sync1, so sync1 gives the
  // direction of the edge.
  assign rise_det = accept & sync1;
  assign fall_det = accept & ~sync1;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      sync0      <= '0;
      sync1      <= '0;
      db_level   <= '0;
      rise_pulse <= '0;
      fall_pulse <= '0;
      // NOTE: the counter array is reset explicitly; it is a handful of
      // flops, not a RAM, and a stale partial count must not survive reset.
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      sync0      <= raw_in;
      sync1      <= sync0;
      db_level   <= db_level ^ accept;
      rise_pulse <= rise_det;
      fall_pulse <= fall_det;
      for (int i = 0; i < N; i++) cnt[i] <= cnt_next[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Optional press-toggled latch
  // ---------------------------------------------------------------------------
`ifdef DEBOUNCE_TOGGLE_EN
  always_ff @(posedge clk) begin
    if (!reset_n) toggle_out <= '0;
    else          toggle_out <= toggle_out ^ rise_det;
  end
`else
  assign toggle_out = '0;
`endif

endmodule

// File: tb/tb_button_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_button_debounce_bank
//   Self-checking bench for button_debounce_bank with STABLE_COUNT=4, CNT_W=3.
//   The reference model treats the synchronizer as a two-sample delay and
//   accepts a new level when the last STABLE_COUNT synchronized samples since
//   reset all differ from the current level.
// -----------------------------------------------------------------------------
module tb_button_debounce_bank;

  localparam int N  = 5;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] raw_in;
  logic [N-1:0] db_level;
  logic [N-1:0] rise_pulse;
  logic [N-1:0] fall_pulse;
  logic [N-1:0] toggle_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_debounce_bank #(
    .N           (N),
    .CNT_W       (3),
    .STABLE_COUNT(SC)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .db_level  (db_level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .toggle_out(toggle_out)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [N-1:0]  m_pipe0, m_pipe1;      // raw delayed by one and two edges
  logic [N-1:0]  m_level, m_rise, m_fall;
  logic [SC-1:0] m_hist [N];            // most recent synchronized samples
  int            m_nval [N];            // samples seen since reset (saturating)
  logic [N-1:0]  m_acc;
  logic [N-1:0]  exp_tog;

  always_comb begin
    m_acc = '0;
    for (int i = 0; i < N; i++)
      m_acc[i] = (m_nval[i] >= SC - 1) &&
                 ({m_hist[i][SC-2:0], m_pipe1[i]} == {SC{~m_level[i]}});
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      m_pipe0 <= '0;
      m_pipe1 <= '0;
      m_level <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
      for (int i = 0; i < N; i++) begin
        m_hist[i] <= '0;
        m_nval[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_hist[i] <= {m_hist[i][SC-2:0], m_pipe1[i]};
        m_nval[i] <= (m_nval[i] < SC) ? m_nval[i] + 1 : SC;
      end
      m_level <= m_level ^ m_acc;
      m_rise  <= m_acc & m_pipe1;
      m_fall  <= m_acc & ~m_pipe1;
      m_pipe0 <= raw_in;
      m_pipe1 <= m_pipe0;
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  logic [N-1:0] m_tog;
  always @(posedge clk) begin
    if (!reset_n) m_tog <= '0;
    else          m_tog <= m_tog ^ (m_acc & m_pipe1);
  end
  assign exp_tog = m_tog;
`else
  assign exp_tog = '0;
`endif

  wire [4*N-1:0] got   = {db_level, rise_pulse, fall_pulse, toggle_out};
  wire [4*N-1:0] exp_v = {m_level, m_rise, m_fall, exp_tog};

  // ---------------------------------------------------------------------------
  // Scenario 1: reset with all inputs high, then release
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    raw_in  = 5'h1f;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", got);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 12) raw_in = 5'h00;
      @(negedge clk);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset_model c=%0d got=%h exp=%h", c, got, exp_v);
      end
      if (c == 4) begin
        checks++;
        if (db_level !== 5'h00) begin
          errors++;
          $display("FAIL reset_early_level got=%h exp=00", db_level);
        end
      end
      if (c == 5) begin
        checks++;
        if ({db_level, rise_pulse, fall_pulse} !== {5'h1f, 5'h1f, 5'h00}) begin
          errors++;
          $display("FAIL reset_rise got=%h/%h/%h exp=1f/1f/00",
                   db_level, rise_pulse, fall_pulse);
        end
      end
      if (c == 6) begin
        checks++;
        if ({db_level, rise_pulse} !== {5'h1f, 5'h00}) begin
          errors++;
          $display("FAIL reset_pulse_width got=%h/%h exp=1f/00", db_level, rise_pulse);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenario 2: clean press and release on channel 0
  // ---------------------------------------------------------------------------
  task automatic test_clean_press();
    int rises = 0, falls = 0, rise_at = -1, fall_at = -1;
    for (int c = 0; c < 24; c++) begin
      raw_in = (c < 10) ? 5'b00001 : 5'b00000;
      @(negedge clk);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL press_model c=%0d got=%h exp=%h", c, got, exp_v);
      end
      if (rise_pulse[0]) begin rises++; rise_at = c; end
      if (fall_pulse[0]) begin falls++; fall_at = c; end
      checks++;
      if ({db_level[4:1], rise_pulse[4:1], fall_pulse[4:1]} !== '0) begin
        errors++;
        $display("FAIL press_other_channels c=%0d got=%h exp=0", c,
                 {db_level[4:1], rise_pulse[4:1], fall_pulse[4:1]});
      end
    end
    checks++;
    if (rises != 1 || rise_at != 5 || falls != 1 || fall_at != 15) begin
      errors++;
      $display("FAIL press_timing rises=%0d@%0d falls=%0d@%0d exp 1@5 1@15",
               rises, rise_at, falls, fall_at);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenario 3: bouncing input on channel 1 settles high
  // ---------------------------------------------------------------------------
  task automatic test_bounce();
    int rises = 0, rise_at = -1;
    for (int c = 0; c < 30; c++) begin
      raw_in    = '0;
      raw_in[1] = (c < 8) ? (((c / 2) % 2) == 0) : (c < 20);
      @(negedge clk);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL bounce_model c=%0d got=%h exp=%h", c, got, exp_v);
      end
      if (rise_pulse[1]) begin rises++; rise_at = c; end
      if (c < 13) begin
        checks++;
        if (db_level[1] !== 1'b0) begin
          errors++;
          $display("FAIL bounce_early c=%0d got=%b exp=0", c, db_level[1]);
        end
      end
    end
    checks++;
    if (rises != 1 || rise_at != 13) begin
      errors++;
      $display("FAIL bounce_rise count=%0d at=%0d exp 1 at 13", rises, rise_at);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenario 4: glitch shorter than the qualification window on channel 2
  // ---------------------------------------------------------------------------
  task automatic test_glitch();
    for (int c = 0; c < 12; c++) begin
      raw_in    = '0;
      raw_in[2] = (c < 3);
      @(negedge clk);
      checks++;
      if ({db_level[2], rise_pulse[2], fall_pulse[2]} !== 3'b000) begin
        errors++;
        $display("FAIL glitch c=%0d got=%b exp=000", c,
                 {db_level[2], rise_pulse[2], fall_pulse[2]});
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenario 5: reset mid-qualification on channel 3
  // ---------------------------------------------------------------------------
  task automatic test_reset_mid();
    int rises = 0, rise_at = -1;
    for (int c = 0; c < 24; c++) begin
      raw_in    = '0;
      raw_in[3] = (c < 16);
      reset_n   = (c != 4);
      @(negedge clk);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL rstmid_model c=%0d got=%h exp=%h", c, got, exp_v);
      end
      if (rise_pulse[3]) begin rises++; rise_at = c; end
      if (c == 4) begin
        checks++;
        if (got !== '0) begin
          errors++;
          $display("FAIL rstmid_cleared got=%h exp=0", got);
        end
      end
    end
    checks++;
    if (rises != 1 || rise_at != 10) begin
      errors++;
      $display("FAIL rstmid_rise count=%0d at=%0d exp 1 at 10", rises, rise_at);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenario 6: two clean presses on channel 4 drive the toggle latch
  // ---------------------------------------------------------------------------
  task automatic test_toggle();
    int   rises = 0;
    logic prev  = toggle_out[4];
    for (int c = 0; c < 40; c++) begin
      raw_in    = '0;
      raw_in[4] = ((c % 20) < 8);
      @(negedge clk);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL toggle_model c=%0d got=%h exp=%h", c, got, exp_v);
      end
      if (rise_pulse[4]) rises++;
`ifdef DEBOUNCE_TOGGLE_EN
      checks++;
      if (toggle_out[4] !== (rises % 2 == 1) ||
          ((toggle_out[4] !== prev) && !rise_pulse[4])) begin
        errors++;
        $display("FAIL toggle_flip c=%0d got=%b exp=%b", c, toggle_out[4], rises % 2 == 1);
      end
`else
      checks++;
      if (toggle_out !== 5'b00000) begin
        errors++;
        $display("FAIL toggle_off c=%0d got=%b exp=00000", c, toggle_out);
      end
`endif
      prev = toggle_out[4];
    end
    checks++;
    if (rises != 2) begin
      errors++;
      $display("FAIL toggle_presses got=%0d exp=2", rises);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Randomized traffic on all channels with occasional resets
  // ---------------------------------------------------------------------------
  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 800; c++) begin
      if (hold == 0) begin
        raw_in = N'($urandom);
        hold   = $urandom_range(1, 7);
      end
      hold--;
      reset_n = ($urandom_range(0, 59) != 0);
      @(negedge clk);
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL random_model c=%0d got=%h exp=%h", c, got, exp_v);
      end
      checks++;
      if ((rise_pulse & fall_pulse) !== '0) begin
        errors++;
        $display("FAIL random_both_pulses c=%0d got=%b exp=00000", c, rise_pulse & fall_pulse);
      end
    end
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    raw_in  = '0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_mid();
    test_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
